// File: rtl/apb4_master_bridge.sv
// ============================================================================
// Module  : apb4_master_bridge
// Purpose : Command/response to APB4 master bridge with wait-state timeout.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_CNT_W-1:0]      r_wait_cnt;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [DATA_WIDTH/8-1:0] r_pstrb;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_slverr;
  logic                    r_rsp_timeout;
  logic                    w_timeout;

  // pready has priority over the timeout in the final wait cycle
  assign w_timeout = (r_state == S_ACCESS) && !pready && (r_wait_cnt == c_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (pready || w_timeout) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_paddr    <= cmd_addr;
            r_pwrite   <= cmd_write;
            r_pwdata   <= cmd_wdata;
            r_pstrb    <= cmd_write ? cmd_strb : '0;
            r_psel     <= 1'b1;
            r_penable  <= 1'b0;
            r_wait_cnt <= '0;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
        end
        S_ACCESS: begin
          if (pready) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_slverr  <= pslverr;
            r_rsp_timeout <= 1'b0;
          end else if (w_timeout) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Gated by rst so no command is taken while reset is held
  assign cmd_ready   = (r_state == S_IDLE) && !rst;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = 3'b000;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;

endmodule

`default_nettype wire

// File: tb/tb_apb4_master_bridge.sv
// ============================================================================
// Module  : tb_apb4_master_bridge
// Purpose : Scoreboard bench for apb4_master_bridge with a scripted APB slave.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_apb4_master_bridge;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [2:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb4_master_bridge #(
    .ADDR_WIDTH    (3),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scripted slave: pready after slv_wait ACCESS cycles unless hung
  logic [31:0] slv_rdata = 32'h0;
  int          slv_wait  = 0;
  logic        slv_err   = 1'b0;
  logic        slv_hang  = 1'b0;
  int          acc_cnt   = 0;

  always @(posedge clk) begin
    if (psel && penable) acc_cnt <= acc_cnt + 1;
    else                 acc_cnt <= 0;
  end

  assign pready  = psel && penable && !slv_hang && (acc_cnt == slv_wait);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
    int          psel_c;
    int          pen_c;
    logic [3:0]  strb;
  } exp_t;

  exp_t exp_q[$];

  int          rec_psel;
  int          rec_pen;
  logic        rec_stable;
  logic [2:0]  rec_addr;
  logic [31:0] rec_wdata;
  logic        rec_write;
  logic [3:0]  rec_strb;

  // Bus recorder followed by response monitor, both at the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (psel && !penable) begin
        rec_psel   = 1;
        rec_pen    = 0;
        rec_stable = 1'b1;
        rec_addr   = paddr;
        rec_wdata  = pwdata;
        rec_write  = pwrite;
        rec_strb   = pstrb;
      end else if (psel) begin
        rec_psel++;
        rec_pen++;
        if (paddr != rec_addr || pwdata != rec_wdata || pwrite != rec_write || pstrb != rec_strb)
          rec_stable = 1'b0;
      end else if (penable) begin
        rec_stable = 1'b0;
      end

      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata",   rsp_rdata,          e.rdata);
          chk("rsp_slverr",  {31'd0, rsp_slverr}, {31'd0, e.slverr});
          chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.tmo});
          chk("psel_cycles", rec_psel,           e.psel_c);
          chk("pen_cycles",  rec_pen,            e.pen_c);
          chk("pstrb_setup", {28'd0, rec_strb},  {28'd0, e.strb});
          chk("bus_stable",  {31'd0, rec_stable}, 32'd1);
        end
      end
    end
  end

  int acc_at;

  task automatic send(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] erd, input logic eerr,
                      input logic etmo, input int epsel, input int epen, input logic push);
    int n;
    exp_t e;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_strb  = st;
    if (push) begin
      e.rdata = erd; e.slverr = eerr; e.tmo = etmo;
      e.psel_c = epsel; e.pen_c = epen; e.strb = wr ? st : 4'h0;
      exp_q.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'd0, 32'd1);
    acc_at = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("rsp_wait_timeout", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b1;
    #22;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_psel",      {31'd0, psel},      32'd0);
    chk("rst_penable",   {31'd0, penable},   32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_paddr_pwdata_pstrb", {25'd0, paddr, pstrb} | pwdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Write, zero wait states; prdata nonzero must not leak into a write response
    slv_rdata = 32'hDEADBEEF;
    send(1'b1, 3'h0, 32'h000000EF, 4'hF, 32'h0, 1'b0, 1'b0, 2, 1, 1'b1);
    wait_idle();

    // Back-to-back reads spaced 4 cycles
    slv_rdata = 32'h000000EF;
    send(1'b0, 3'h0, 32'hFFFFFFFF, 4'hF, 32'h000000EF, 1'b0, 1'b0, 2, 1, 1'b1);
    a0 = acc_at;
    send(1'b0, 3'h2, 32'h0, 4'hF, 32'h000000EF, 1'b0, 1'b0, 2, 1, 1'b1);
    chk("b2b_spacing", acc_at - a0, 32'd4);
    wait_idle();

    // Three wait states with pslverr on completion
    slv_wait = 3; slv_err = 1'b1;
    send(1'b1, 3'h5, 32'h12345678, 4'h6, 32'h0, 1'b1, 1'b0, 5, 4, 1'b1);
    wait_idle();
    slv_err = 1'b0;

    // Slave never ready: abort after 16 ACCESS cycles
    slv_hang = 1'b1; slv_rdata = 32'h0000AAAA;
    send(1'b0, 3'h3, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 17, 16, 1'b1);
    wait_idle();
    slv_hang = 1'b0;

    // pready on the 16th ACCESS cycle wins over the timeout
    slv_wait = 15; slv_rdata = 32'h5A5A5A5A;
    send(1'b0, 3'h7, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 1'b0, 17, 16, 1'b1);
    wait_idle();

    // Response backpressure
    slv_wait = 0; slv_rdata = 32'h000000C3; rsp_ready = 1'b0;
    send(1'b0, 3'h1, 32'h0, 4'h0, 32'h000000C3, 1'b0, 1'b0, 2, 1, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h000000C3);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_rsp_valid_clear", {31'd0, rsp_valid}, 32'd0);

    // Asynchronous reset in the middle of ACCESS
    slv_hang = 1'b1;
    send(1'b1, 3'h4, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n = 0;
    while (!penable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_access_penable", {31'd0, penable}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_psel",      {31'd0, psel},      32'd0);
    chk("arst_penable",   {31'd0, penable},   32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    #1 rst = 1'b0;
    slv_hang = 1'b0;
    @(negedge clk);
    chk("post_arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("post_arst_psel", {31'd0, psel}, 32'd0);

    chk("pprot", {29'd0, pprot}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb4_master_bridge.md
APB4_MASTER_BRIDGE -- requirements
Module: apb4_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, meaning APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum ACCESS cycles waited for pready.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-005 SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_slverr  out  1  pslverr captured, or timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- psel  out  1  APB4 select.
- penable  out  1  APB4 enable.
- pwrite  out  1  APB4 direction.
- paddr  out  ADDR_WIDTH  APB4 address.
- pwdata  out  DATA_WIDTH  APB4 write data.
- pstrb  out  DATA_WIDTH/8  APB4 strobes; forced to 0 on reads.
- pprot  out  3  fixed 3'b000.
- prdata  in  DATA_WIDTH  APB4 read data.
- pready  in  1  APB4 ready.
- pslverr  in  1  APB4 error.

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, with all APB and response outputs registered.
REQ-007 SHALL drive cmd_ready=1 only in IDLE; acceptance SHALL latch cmd_write, cmd_addr, cmd_wdata and cmd_strb into paddr, pwrite, pwdata and pstrb, and move to SETUP.
REQ-008 SETUP SHALL last exactly one cycle, with psel=1 and penable=0, then move to ACCESS.
REQ-009 In ACCESS, psel=1 and penable=1; paddr, pwrite, pwdata and pstrb SHALL stay stable from SETUP until the transfer ends.
REQ-010 ACCESS with pready=1 SHALL, in that cycle:
- capture prdata (reads only, else 0) into rsp_rdata;
- capture pslverr into rsp_slverr;
- set rsp_timeout=0 and rsp_valid=1;
- clear psel and penable;
- move to RESP.
REQ-011 ACCESS with pready=0 SHALL increment a wait counter of width $clog2(TIMEOUT_CYCLES+1); the counter SHALL clear on entry to SETUP.
REQ-012 When the wait counter equals TIMEOUT_CYCLES-1 and pready=0, the bridge SHALL abort:
- clear psel and penable;
- rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0;
- move to RESP.
REQ-013 pready=1 in the same cycle as the timeout condition SHALL complete normally (pready wins).
REQ-014 RESP SHALL hold rsp_valid and the response fields stable until rsp_ready=1, then return to IDLE with rsp_valid=0 the next cycle.
REQ-015 No new command SHALL be accepted while rsp_valid=1; with rsp_ready held at 1, minimum command-to-command spacing SHALL be 4 cycles.
REQ-016 psel SHALL never be asserted outside SETUP and ACCESS; penable SHALL never be 1 while psel=0.
REQ-017 pprot SHALL be 3'b000 at all times.

Reset
REQ-018 rst=1 SHALL immediately (asynchronously) force:
- state to IDLE;
- psel, penable, pwrite, rsp_valid, rsp_slverr and rsp_timeout to 0;
- paddr, pwdata, pstrb, rsp_rdata and the wait counter to 0.
REQ-019 cmd_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst falls.
REQ-020 Reset asserted during SETUP, ACCESS or RESP SHALL drop psel and penable within the same cycle and discard the transaction with no response.

Verification
REQ-021 Write: addr=0x0, wdata=0x000000EF, strb=0xF, pready tied to 1 -> psel for 2 cycles, penable in the 2nd, then rsp_valid=1, rsp_slverr=0, rsp_rdata=0.
REQ-022 Read: addr=0x0 to a slave returning 0x000000EF -> pstrb=0, rsp_rdata=0x000000EF; back-to-back reads with rsp_ready=1 spaced exactly 4 cycles.
REQ-023 Wait states: slave holds pready=0 for 3 ACCESS cycles and asserts pslverr with pready -> penable for 4 cycles, paddr and pwdata stable, rsp_slverr=1, rsp_timeout=0.
REQ-024 Timeout: pready=0 forever with TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; pready=1 on the 16th ACCESS cycle instead -> normal completion.
REQ-025 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data held, cmd_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-026 Reset mid-ACCESS: rst pulses between clock edges -> psel, penable and rsp_valid go to 0 without a clock edge, no response issued, cmd_ready=1 after release.
